ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage. Consumes the decoded mult/div request and forwarded operands that the ID/EX pipeline register presents.
- Owns the architectural HI/LO registers.
- Asserts busy to the hazard unit so that a following mfhi/mflo/mult/div stalls in ID until the result is written.

---
 rtl/ex_muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit owning HI/LO; one iteration per cycle.
// Optional MULDIV_CANCEL_EN adds a cancel input to abort an in-flight operation.
module ex_muldiv_unit #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [DATA_W-1:0] mt_data,
`ifdef MULDIV_CANCEL_EN
   input  logic              cancel,
`endif
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam int unsigned ACC_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic [ACC_W-1:0]    acc;
   logic [DATA_W-1:0]   opnd;
   logic                is_div;
   logic                q_neg;
   logic                r_neg;

   logic                cancel_c;
   logic                signed_op_c;
   logic                a_neg_c;
   logic                b_neg_c;
   logic [DATA_W-1:0]   a_mag_c;
   logic [DATA_W-1:0]   b_mag_c;
   logic [DATA_W:0]     mul_sum_c;
   logic [DATA_W:0]     div_shift_c;
   logic                div_ge_c;
   logic [ACC_W-1:0]    acc_step_c;
   logic [ACC_W-1:0]    prod_c;
   logic [DATA_W-1:0]   quot_c;
   logic [DATA_W-1:0]   rem_c;

`ifdef MULDIV_CANCEL_EN
   assign cancel_c = cancel;
`else
   assign cancel_c = 1'b0;
`endif

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Operand magnitudes; magnitude of the most negative value is its unsigned pattern.
   always_comb begin
      signed_op_c = ~op[0];
      a_neg_c     = signed_op_c & src_a[DATA_W-1];
      b_neg_c     = signed_op_c & src_b[DATA_W-1];
      a_mag_c     = a_neg_c ? -src_a : src_a;
      b_mag_c     = b_neg_c ? -src_b : src_b;
   end

   // One shift-add (multiply) or restoring-subtract (divide) step.
   // Multiply: acc = {partial product high, multiplier shifting out}.
   // Divide:   acc = {partial remainder, dividend shifting out / quotient shifting in}.
   always_comb begin
      mul_sum_c   = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift_c = {acc[ACC_W-1:DATA_W], acc[DATA_W-1]};
      div_ge_c    = (div_shift_c >= {1'b0, opnd});
      if (is_div) begin
         acc_step_c = {(div_ge_c ? DATA_W'(div_shift_c - {1'b0, opnd})
                                 : div_shift_c[DATA_W-1:0]),
                       acc[DATA_W-2:0], div_ge_c};
      end else begin
         acc_step_c = {mul_sum_c, acc[DATA_W-1:1]};
      end
   end

   // Sign correction applied when results are committed.
   always_comb begin
      prod_c = q_neg ? -acc : acc;
      quot_c = q_neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
      rem_c  = r_neg ? -acc[ACC_W-1:DATA_W] : acc[ACC_W-1:DATA_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (!cancel_c) begin
                     state  <= RUN;
                     count  <= '0;
                     is_div <= op[1];
                     opnd   <= op[1] ? b_mag_c : a_mag_c;
                     acc    <= {{DATA_W{1'b0}}, (op[1] ? a_mag_c : b_mag_c)};
                     // Divide by zero keeps an all-ones quotient regardless of sign.
                     q_neg  <= (a_neg_c ^ b_neg_c) & (~op[1] | (|src_b));
                     r_neg  <= a_neg_c;
                  end
               end else begin
                  if (mthi) hi <= mt_data;
                  if (mtlo) lo <= mt_data;
               end
            end
            RUN: begin
               if (cancel_c) begin
                  state <= IDLE;
               end else begin
                  acc   <= acc_step_c;
                  count <= count + CNT_W'(1);
                  if (count == CNT_W'(DATA_W - 1)) state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               if (!cancel_c) begin
                  if (is_div) begin
                     hi <= rem_c;
                     lo <= quot_c;
                  end else begin
                     hi <= prod_c[ACC_W-1:DATA_W];
                     lo <= prod_c[DATA_W-1:0];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic              mthi;
   logic              mtlo;
   logic [DATA_W-1:0] mt_data;
`ifdef MULDIV_CANCEL_EN
   logic              cancel;
`endif
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   int                n_checks = 0;
   int                n_pass = 0;
   logic [DATA_W-1:0] exp_hi;
   logic [DATA_W-1:0] exp_lo;

   ex_muldiv_unit #(.DATA_W(DATA_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .mthi    (mthi),
      .mtlo    (mtlo),
      .mt_data (mt_data),
`ifdef MULDIV_CANCEL_EN
      .cancel  (cancel),
`endif
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference result {hi, lo} from plain arithmetic.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint p;
      int     sa;
      int     sb;
      logic [31:0] q;
      logic [31:0] r;
      if (o == 2'd0) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return p;
      end
      if (o == 2'd1) return {32'h0, a} * {32'h0, b};
      if (b == 32'h0) return {a, 32'hFFFFFFFF};
      if (o == 2'd3) begin
         q = a / b;
         r = a % b;
         return {r, q};
      end
      sa = $signed(a);
      sb = $signed(b);
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      return {r, q};
   endfunction

   // mode: 0 normal, 1 inject ignored start/mthi at T+10, 2 reset at T+15,
   //       3 cancel at T+15, 4 hold start for back-to-back issue
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int mode);
      logic [63:0] r;
      int          busy_hi;
      int          done_at;
      int          done_cnt;
      int          waited;
      r        = model(o, a, b);
      busy_hi  = 0;
      done_at  = 0;
      @(negedge clk);
      op      = o;
      src_a   = a;
      src_b   = b;
      start   = 1'b1;
      mthi    = 1'($urandom_range(0, 1));
      mt_data = $urandom;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (mode != 4) start = 1'b0;
            mthi = 1'b0;
         end
         if (busy) busy_hi++;
         if (done && done_at == 0) done_at = k;
         if (mode == 1 && k == 10) begin
            start = 1'b1; op = 2'd1; src_a = 32'h2; src_b = 32'h3;
            mthi = 1'b1; mt_data = 32'hAAAA;
         end
         if (mode == 1 && k == 11) begin
            start = 1'b0; mthi = 1'b0;
         end
         if (mode == 2 && k == 15) reset = 1'b1;
`ifdef MULDIV_CANCEL_EN
         if (mode == 3 && k == 15) cancel = 1'b1;
`endif
         if ((mode == 2 || mode == 3) && k == 16) begin
            reset = 1'b0;
`ifdef MULDIV_CANCEL_EN
            cancel = 1'b0;
`endif
            if (mode == 2) begin
               exp_hi = '0;
               exp_lo = '0;
            end
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_hi", hi, exp_hi);
            check("abort_lo", lo, exp_lo);
            done_cnt = 0;
            for (int j = 0; j < 25; j++) begin
               @(negedge clk);
               if (done || busy) done_cnt++;
            end
            check("abort_quiet", done_cnt, 0);
            check("abort_hold_hi", hi, exp_hi);
            return;
         end
      end
      check("busy_cycles", busy_hi, 33);
      check("done_cycle", done_at, 33);
      @(negedge clk);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("res_hi", hi, exp_hi);
      check("res_lo", lo, exp_lo);
      if (mode == 4) begin
         @(negedge clk);
         start = 1'b0;
         check("b2b_busy", busy, 1);
         waited = 0;
         while (busy && waited < 40) begin
            @(negedge clk);
            waited++;
         end
         check("b2b_latency", waited, 33);
         check("b2b_hi", hi, exp_hi);
         check("b2b_lo", lo, exp_lo);
      end
   endtask

   task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
      @(negedge clk);
      mthi = wh; mtlo = wl; mt_data = d;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      if (wh) exp_hi = d;
      if (wl) exp_lo = d;
      check("mt_hi", hi, exp_hi);
      check("mt_lo", lo, exp_lo);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] corners [5];
      corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h80000000;
      corners[3] = 32'hFFFFFFFF; corners[4] = 32'h7FFFFFFF;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      if ($urandom_range(0, 2) == 0) return $urandom_range(0, 20);
      return $urandom;
   endfunction

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
      mthi = 1'b0; mtlo = 1'b0; mt_data = '0;
`ifdef MULDIV_CANCEL_EN
      cancel = 1'b0;
`endif
      repeat (3) @(negedge clk);
      exp_hi = '0;
      exp_lo = '0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      reset = 1'b0;

      run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      check("multu_max_hi", hi, 32'hFFFFFFFE);
      run_op(2'd0, 32'hFFFFFFFD, 32'h7, 0);
      check("mult_neg_lo", lo, 32'hFFFFFFEB);
      run_op(2'd2, 32'hFFFFFFF9, 32'h2, 0);
      check("div_neg_lo", lo, 32'hFFFFFFFD);
      run_op(2'd3, 32'd100, 32'd7, 0);
      check("divu_rem", hi, 32'h2);
      run_op(2'd3, 32'd5, 32'd0, 0);
      check("divu_zero_lo", lo, 32'hFFFFFFFF);
      run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
      check("div_wrap_lo", lo, 32'h80000000);
      run_op(2'd2, 32'hFFFFFF00, 32'h0, 0);
      run_op(2'd0, 32'h80000000, 32'h80000000, 0);
      run_op(2'd1, 32'h12345678, 32'h9ABCDEF0, 1);
      mt_write(1'b0, 1'b1, 32'h1234);
      mt_write(1'b1, 1'b1, 32'hCAFEF00D);
      run_op(2'd3, 32'd1000, 32'd3, 2);
      run_op(2'd0, 32'h00012345, 32'hFFFF0001, 0);
`ifdef MULDIV_CANCEL_EN
      run_op(2'd3, 32'd77, 32'd5, 3);
`endif
      run_op(2'd2, 32'h7FFFFFFF, 32'hFFFFFFFD, 4);

      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom_range(0, 3)), pick(), pick(), 0);
         if ($urandom_range(0, 4) == 0)
            mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
